// File: rtl/sum_vector_dispatcher.sv
// sum_vector_dispatcher: buffers {a,b,c,n} job descriptors and calls the
// sum_vector component one job at a time, producing a completion record per job.
// Ports: clock/resetn (sync, active-low); desc_* descriptor push (valid/ready);
// pause gates dispatch; comp_* call (start/busy) and return (done/stall) with
// sum_vector; cpl_* completion record {id, cycles, skipped} (valid/ready);
// fifo_count = descriptors buffered; idle = nothing queued, running or pending.
module sum_vector_dispatcher #(
    parameter int DEPTH     = 4,
    parameter int ID_W      = 8,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     desc_valid,
    output logic                     desc_ready,
    input  logic [63:0]              desc_a,
    input  logic [63:0]              desc_b,
    input  logic [63:0]              desc_c,
    input  logic [31:0]              desc_n,
    input  logic                     pause,
    output logic                     comp_start,
    input  logic                     comp_busy,
    output logic [63:0]              comp_a,
    output logic [63:0]              comp_b,
    output logic [63:0]              comp_c,
    output logic [31:0]              comp_n,
    input  logic                     comp_done,
    output logic                     comp_stall,
    output logic                     cpl_valid,
    input  logic                     cpl_ready,
    output logic [ID_W-1:0]          cpl_id,
    output logic [31:0]              cpl_cycles,
    output logic                     cpl_skipped,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     idle
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [31:0] n;
    } desc_t;

    typedef enum logic [1:0] {IDLE, CALL, WAIT, HOLD} state_t;

    desc_t           mem_q [DEPTH];
    desc_t           desc_in, head;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    state_t          state_q, state_d;
    desc_t           args_q, args_d;
    logic [ID_W-1:0] next_id_q, next_id_d, job_id_q, job_id_d;
    logic [31:0]     cnt_q, cnt_d, cnt_inc;
    logic            cpl_valid_q, cpl_valid_d;
    logic [ID_W-1:0] cpl_id_q, cpl_id_d;
    logic [31:0]     cpl_cycles_q, cpl_cycles_d;
    logic            cpl_skipped_q, cpl_skipped_d;
    logic            push, pop;

    // No bypass: a full FIFO refuses even when it is popped this cycle.
    assign desc_ready = resetn && (count_q != FULL_CNT);
    assign push       = desc_valid && desc_ready;
    assign desc_in    = {desc_a, desc_b, desc_c, desc_n};
    assign head       = mem_q[rd_ptr_q];

    // Saturating WAIT-cycle counter.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

    always_comb begin
        state_d       = state_q;
        args_d        = args_q;
        next_id_d     = next_id_q;
        job_id_d      = job_id_q;
        cnt_d         = cnt_q;
        cpl_valid_d   = cpl_valid_q;
        cpl_id_d      = cpl_id_q;
        cpl_cycles_d  = cpl_cycles_q;
        cpl_skipped_d = cpl_skipped_q;
        pop           = 1'b0;
        comp_start    = 1'b0;

        if (cpl_valid_q && cpl_ready) begin
            cpl_valid_d   = 1'b0;
            cpl_id_d      = '0;
            cpl_cycles_d  = '0;
            cpl_skipped_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (count_q != '0 && !pause && !cpl_valid_q) begin
                    pop       = 1'b1;
                    args_d    = head;
                    job_id_d  = next_id_q;
                    next_id_d = next_id_q + 1'b1;
                    if (SKIP_ZERO && head.n == 32'd0) begin
                        cpl_valid_d   = 1'b1;
                        cpl_id_d      = next_id_q;
                        cpl_cycles_d  = '0;
                        cpl_skipped_d = 1'b1;
                    end else begin
                        state_d = CALL;
                    end
                end
            end
            CALL: begin
                comp_start = 1'b1;
                if (!comp_busy) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (comp_done) begin
                    if (!cpl_valid_q) begin
                        cpl_valid_d   = 1'b1;
                        cpl_id_d      = job_id_q;
                        cpl_cycles_d  = cnt_inc;
                        cpl_skipped_d = 1'b0;
                        state_d       = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Counter already includes the done cycle and stays frozen.
                if (!cpl_valid_q) begin
                    cpl_valid_d   = 1'b1;
                    cpl_id_d      = job_id_q;
                    cpl_cycles_d  = cnt_q;
                    cpl_skipped_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= desc_in;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= IDLE;
            args_q        <= '0;
            next_id_q     <= '0;
            job_id_q      <= '0;
            cnt_q         <= '0;
            cpl_valid_q   <= 1'b0;
            cpl_id_q      <= '0;
            cpl_cycles_q  <= '0;
            cpl_skipped_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            args_q        <= args_d;
            next_id_q     <= next_id_d;
            job_id_q      <= job_id_d;
            cnt_q         <= cnt_d;
            cpl_valid_q   <= cpl_valid_d;
            cpl_id_q      <= cpl_id_d;
            cpl_cycles_q  <= cpl_cycles_d;
            cpl_skipped_q <= cpl_skipped_d;
        end
    end

    assign comp_a      = args_q.a;
    assign comp_b      = args_q.b;
    assign comp_c      = args_q.c;
    assign comp_n      = args_q.n;
    assign comp_stall  = cpl_valid_q;
    assign cpl_valid   = cpl_valid_q;
    assign cpl_id      = cpl_id_q;
    assign cpl_cycles  = cpl_cycles_q;
    assign cpl_skipped = cpl_skipped_q;
    assign fifo_count  = count_q;
    assign idle        = (count_q == '0) && (state_q == IDLE) && !cpl_valid_q;

endmodule

// File: tb/tb_sum_vector_dispatcher.sv
// Bench for sum_vector_dispatcher: directed scenarios plus random traffic
// against a queue-based job model and a behavioural sum_vector responder.
module tb_sum_vector_dispatcher;
    localparam int DEPTH = 4;
    localparam int ID_W  = 8;

    logic                   clock = 1'b0;
    logic                   resetn = 1'b0;
    logic                   desc_valid = 1'b0;
    logic                   desc_ready;
    logic [63:0]            desc_a = '0;
    logic [63:0]            desc_b = '0;
    logic [63:0]            desc_c = '0;
    logic [31:0]            desc_n = '0;
    logic                   pause = 1'b0;
    logic                   comp_start;
    logic                   comp_busy = 1'b0;
    logic [63:0]            comp_a, comp_b, comp_c;
    logic [31:0]            comp_n;
    logic                   comp_done = 1'b0;
    logic                   comp_stall;
    logic                   cpl_valid;
    logic                   cpl_ready = 1'b0;
    logic [ID_W-1:0]        cpl_id;
    logic [31:0]            cpl_cycles;
    logic                   cpl_skipped;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   idle;

    always #5 clock = ~clock;

    sum_vector_dispatcher #(.DEPTH(DEPTH), .ID_W(ID_W), .SKIP_ZERO(1'b1)) dut (
        .clock(clock), .resetn(resetn),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_a(desc_a), .desc_b(desc_b), .desc_c(desc_c), .desc_n(desc_n),
        .pause(pause),
        .comp_start(comp_start), .comp_busy(comp_busy),
        .comp_a(comp_a), .comp_b(comp_b), .comp_c(comp_c), .comp_n(comp_n),
        .comp_done(comp_done), .comp_stall(comp_stall),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
        .cpl_id(cpl_id), .cpl_cycles(cpl_cycles), .cpl_skipped(cpl_skipped),
        .fifo_count(fifo_count), .idle(idle)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [31:0] n;
        int          seq;
    } job_t;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model state: jobs in acceptance order, WAIT lengths seen by the responder.
    job_t call_q[$];
    job_t cpl_q[$];
    int   wait_cyc[int];
    int   seq = 0;
    int   cyc = 0;
    int   starts = 0;
    int   cpls = 0;
    int   cpl_ticks = 0;
    int   push_at = 0;
    bit   saw_wrap = 1'b0;

    // Stimulus knobs.
    int   offer_pct = 0, zero_pct = 0, busy_pct = 0, rdy_pct = 100;
    int   pause_pct = 0, lat_lo = 1, lat_hi = 1, busy_force = 0;
    bit   pause_hold = 1'b0;
    bit   forced = 1'b0;
    job_t fd;

    // Responder: 0 ready for a call, 1 computing, 2 done offered.
    int   cm_state = 0, cm_cnt = 0, cm_acc = 0, cm_done_at = 0, cm_seq = 0;

    task automatic tick();
        job_t j;
        job_t h;
        int   exp_cyc;
        if (forced) begin
            desc_valid = 1'b1;
            desc_a = fd.a; desc_b = fd.b; desc_c = fd.c; desc_n = fd.n;
        end else if (int'($urandom_range(99)) < offer_pct) begin
            desc_valid = 1'b1;
            desc_a = {$urandom, $urandom};
            desc_b = {$urandom, $urandom};
            desc_c = {$urandom, $urandom};
            desc_n = (int'($urandom_range(99)) < zero_pct) ? 32'd0
                     : 32'($urandom_range(64, 1));
        end else begin
            desc_valid = 1'b0;
        end
        pause = pause_hold || (int'($urandom_range(99)) < pause_pct);
        comp_busy = 1'b0;
        comp_done = 1'b0;
        case (cm_state)
            0: if (comp_start) begin
                if (busy_force > 0) begin
                    comp_busy = 1'b1;
                    busy_force--;
                end else begin
                    comp_busy = int'($urandom_range(99)) < busy_pct;
                end
            end
            1: if (cm_cnt == 0) begin
                comp_done = 1'b1;
                cm_state = 2;
                cm_done_at = cyc;
            end else begin
                cm_cnt--;
            end
            default: comp_done = 1'b1;
        endcase
        cpl_ready = int'($urandom_range(99)) < rdy_pct;
        #1;
        if (resetn) begin
            if (cm_state == 2 && comp_done && !comp_stall) begin
                wait_cyc[cm_seq] = cm_done_at - cm_acc;
                cm_state = 0;
            end
            if (comp_start) begin
                if (cm_state != 0 || call_q.size() == 0) begin
                    check("start_unexpected", 64'(1), 64'(0));
                end else begin
                    check("comp_a", comp_a, call_q[0].a);
                    check("comp_b", comp_b, call_q[0].b);
                    check("comp_c", comp_c, call_q[0].c);
                    check("comp_n", 64'(comp_n), 64'(call_q[0].n));
                    if (!comp_busy) begin
                        j = call_q.pop_front();
                        cm_seq = j.seq;
                        cm_acc = cyc;
                        cm_state = 1;
                        cm_cnt = int'($urandom_range(lat_hi, lat_lo)) - 1;
                        starts++;
                    end
                end
            end
            if (desc_valid && desc_ready) begin
                j.a = desc_a; j.b = desc_b; j.c = desc_c; j.n = desc_n;
                j.seq = seq;
                seq++;
                cpl_q.push_back(j);
                if (j.n != 32'd0) call_q.push_back(j);
                push_at = cyc;
                forced = 1'b0;
            end
            if (cpl_valid) begin
                cpl_ticks++;
                if (cpl_q.size() == 0) begin
                    check("cpl_unexpected", 64'(1), 64'(0));
                end else begin
                    h = cpl_q[0];
                    if (h.n == 32'd0) exp_cyc = 0;
                    else if (wait_cyc.exists(h.seq)) exp_cyc = wait_cyc[h.seq];
                    else exp_cyc = -1;
                    check("cpl_id", 64'(cpl_id), 64'(h.seq % 256));
                    check("cpl_skipped", 64'(cpl_skipped), 64'(h.n == 32'd0));
                    check("cpl_cycles", 64'(cpl_cycles), 64'(exp_cyc));
                    check("comp_stall", 64'(comp_stall), 64'(1));
                    if (cpl_ready) begin
                        void'(cpl_q.pop_front());
                        cpls++;
                        if (h.seq == 256) saw_wrap = 1'b1;
                    end
                end
            end
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cm_state = 0;
        forced = 1'b0;
        busy_force = 0;
        tick();
        tick();
        call_q.delete();
        cpl_q.delete();
        wait_cyc.delete();
        seq = 0;
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [31:0] n);
        fd.a = a; fd.b = b; fd.c = c; fd.n = n; fd.seq = 0;
        forced = 1'b1;
        for (int k = 0; k < 200 && forced; k++) tick();
        if (forced) begin
            check("send_timeout", 64'(0), 64'(1));
            forced = 1'b0;
        end
    endtask

    task automatic wait_start(input string tag);
        for (int k = 0; k < 200 && !comp_start; k++) tick();
        if (!comp_start) check(tag, 64'(0), 64'(1));
    endtask

    task automatic wait_cpl(input string tag);
        for (int k = 0; k < 300 && !cpl_valid; k++) tick();
        if (!cpl_valid) check(tag, 64'(0), 64'(1));
    endtask

    task automatic drain(input string tag, input int budget);
        offer_pct = 0;
        for (int k = 0; k < budget && !(idle && cpl_q.size() == 0); k++) tick();
        if (!(idle && cpl_q.size() == 0)) check(tag, 64'(0), 64'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, c0, st, t0;

        // Reset state.
        do_reset();
        check("rst_desc_ready", 64'(desc_ready), 64'(0));
        check("rst_comp_start", 64'(comp_start), 64'(0));
        check("rst_comp_stall", 64'(comp_stall), 64'(0));
        check("rst_cpl_valid", 64'(cpl_valid), 64'(0));
        check("rst_cpl_id", 64'(cpl_id), 64'(0));
        check("rst_cpl_cycles", 64'(cpl_cycles), 64'(0));
        check("rst_fifo_count", 64'(fifo_count), 64'(0));
        check("rst_comp_a", comp_a, 64'(0));
        resetn = 1'b1;
        #1;
        check("rst_idle", 64'(idle), 64'(1));
        check("rst_ready_after", 64'(desc_ready), 64'(1));

        // Single job: start two cycles after acceptance, 20 WAIT cycles.
        lat_lo = 20; lat_hi = 20; rdy_pct = 100;
        send(64'h1000, 64'h2000, 64'h3000, 32'd16);
        wait_start("t1_start_timeout");
        check("t1_latency", 64'(cyc - push_at), 64'(2));
        wait_cpl("t1_cpl_timeout");
        check("t1_id", 64'(cpl_id), 64'(0));
        check("t1_cycles", 64'(cpl_cycles), 64'(20));
        check("t1_skipped", 64'(cpl_skipped), 64'(0));
        drain("t1_drain", 50);

        // Busy for 3 cycles: start held 4 cycles with stable arguments.
        lat_lo = 3; lat_hi = 3; busy_force = 3;
        send(64'hAAAA_0000_1111, 64'hBBBB, 64'hCCCC, 32'd5);
        wait_start("t3_start_timeout");
        st = 0;
        while (comp_start && st < 10) begin
            st++;
            tick();
        end
        check("t3_start_len", 64'(st), 64'(4));
        drain("t3_drain", 50);

        // Paused FIFO fills to DEPTH, then releases in order.
        pause_hold = 1'b1; offer_pct = 100; zero_pct = 0; lat_lo = 1; lat_hi = 4;
        s0 = seq; c0 = cpls;
        for (int k = 0; k < 6; k++) tick();
        check("t2_count", 64'(fifo_count), 64'(DEPTH));
        check("t2_ready_full", 64'(desc_ready), 64'(0));
        check("t2_accepted", 64'(seq - s0), 64'(DEPTH));
        check("t2_no_start", 64'(comp_start), 64'(0));
        pause_hold = 1'b0;
        for (int k = 0; k < 100 && seq - s0 < 5; k++) tick();
        check("t2_fifth_accepted", 64'(seq - s0), 64'(5));
        drain("t2_drain", 300);
        check("t2_cpls", 64'(cpls - c0), 64'(5));

        // Record held unconsumed blocks further dispatch.
        rdy_pct = 0; lat_lo = 3; lat_hi = 3;
        s0 = starts;
        send(64'h11, 64'h22, 64'h33, 32'd7);
        send(64'h44, 64'h55, 64'h66, 32'd9);
        wait_cpl("t4_cpl_timeout");
        for (int k = 0; k < 5; k++) tick();
        check("t4_hold_valid", 64'(cpl_valid), 64'(1));
        check("t4_stall", 64'(comp_stall), 64'(1));
        check("t4_one_start", 64'(starts - s0), 64'(1));
        check("t4_queued", 64'(fifo_count), 64'(1));
        rdy_pct = 100;
        tick();
        rdy_pct = 0;
        check("t4_cleared", 64'(cpl_valid), 64'(0));
        wait_cpl("t4_cpl2_timeout");
        check("t4_second_id", 64'(cpl_id), 64'((seq - 1) % 256));
        rdy_pct = 100;
        drain("t4_drain", 100);

        // Zero-length job is completed without a call.
        s0 = starts;
        send(64'h5, 64'h6, 64'h7, 32'd0);
        wait_cpl("t5_cpl_timeout");
        check("t5_skipped", 64'(cpl_skipped), 64'(1));
        check("t5_cycles", 64'(cpl_cycles), 64'(0));
        check("t5_id", 64'(cpl_id), 64'((seq - 1) % 256));
        drain("t5_drain", 50);
        check("t5_no_start", 64'(starts - s0), 64'(0));

        // Random traffic past the id wrap.
        do_reset();
        resetn = 1'b1;
        offer_pct = 40; zero_pct = 20; busy_pct = 30; rdy_pct = 60;
        pause_pct = 10; lat_lo = 1; lat_hi = 6;
        for (int k = 0; k < 20000 && seq < 300; k++) tick();
        pause_pct = 0;
        drain("rand_drain", 2000);
        check("rand_jobs", 64'(seq >= 300), 64'(1));
        check("wrap_reached", 64'(saw_wrap), 64'(1));

        // Reset during WAIT with two descriptors queued.
        rdy_pct = 100; busy_pct = 0; zero_pct = 0; lat_lo = 40; lat_hi = 40;
        send(64'h100, 64'h200, 64'h300, 32'd3);
        send(64'h101, 64'h201, 64'h301, 32'd4);
        send(64'h102, 64'h202, 64'h302, 32'd5);
        for (int k = 0; k < 20 && !(cm_state == 1 && fifo_count == 2); k++) tick();
        check("t6_setup", 64'(cm_state == 1 && fifo_count == 2), 64'(1));
        do_reset();
        check("t6_comp_start", 64'(comp_start), 64'(0));
        check("t6_cpl_valid", 64'(cpl_valid), 64'(0));
        check("t6_fifo_count", 64'(fifo_count), 64'(0));
        check("t6_comp_n", 64'(comp_n), 64'(0));
        check("t6_desc_ready", 64'(desc_ready), 64'(0));
        resetn = 1'b1;
        t0 = cpl_ticks;
        for (int k = 0; k < 30; k++) tick();
        check("t6_no_cpl", 64'(cpl_ticks - t0), 64'(0));
        lat_lo = 2; lat_hi = 2;
        send(64'h900, 64'h901, 64'h902, 32'd8);
        wait_cpl("t6_cpl_timeout");
        check("t6_id_zero", 64'(cpl_id), 64'(0));
        drain("t6_drain", 50);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
